// File: rtl/keypad_encoder.sv
// Debounced 12-key telephone keypad to ASCII encoder with a one-cycle CHK strobe and star/sharp flags.
// Optional build macro KEYPAD_PRIORITY_EN: multi-key codes resolve to their lowest-index key.
module keypad_encoder #(
    parameter int DEBOUNCE = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [11:0] Keypad,
    output logic [7:0]  LCD_DATA,
    output logic        CHK,
    output logic        star,
    output logic        sharp,
    output logic [0:0]  o_state
);

    typedef enum logic [0:0] {
        ST_FREE    = 1'b0,
        ST_LATCHED = 1'b1
    } state_t;

    localparam logic [3:0] DB_COUNT = 4'(DEBOUNCE);

    state_t      r_state;
    state_t      w_state_next;
    logic [11:0] r_prev_code;
    logic        r_prev_invalid;
    logic [3:0]  r_count;
    logic [7:0]  r_lcd_data;
    logic        r_chk;
    logic        r_star;
    logic        r_sharp;

    logic        w_is_zero;
    logic        w_is_onehot;
    logic        w_key_valid;
    logic        w_invalid;
    logic [11:0] w_code;
    logic [3:0]  w_count_next;
    logic        w_stable;
    logic [7:0]  w_ascii;
    logic        w_accept;
    logic        w_release;

    assign w_is_zero   = (Keypad == 12'h000);
    assign w_is_onehot = !w_is_zero && ((Keypad & (Keypad - 12'd1)) == 12'h000);

`ifdef KEYPAD_PRIORITY_EN
    logic [11:0] w_lowest;
    // Two's-complement trick isolates the lowest set bit.
    assign w_lowest    = Keypad & (~Keypad + 12'd1);
    assign w_key_valid = !w_is_zero;
    assign w_code      = w_lowest;
`else
    assign w_key_valid = w_is_onehot;
    assign w_code      = w_is_onehot ? Keypad : 12'h000;
`endif

    assign w_invalid = !w_is_zero && !w_key_valid;

    // Invalid codes zero the run and mark the history so the next code always restarts at 1.
    always_comb begin
        w_count_next = r_count;
        if (w_invalid) begin
            w_count_next = 4'd0;
        end else if (r_prev_invalid || (w_code != r_prev_code)) begin
            w_count_next = 4'd1;
        end else if (r_count != 4'hF) begin
            w_count_next = r_count + 4'd1;
        end
    end

    assign w_stable = (w_count_next >= DB_COUNT);

    always_comb begin
        w_ascii = 8'h00;
        for (int i = 0; i < 10; i++) begin
            if (w_code[i]) begin
                w_ascii = 8'h30 + 8'(i);
            end
        end
        if (w_code[10]) begin
            w_ascii = 8'h2A;
        end
        if (w_code[11]) begin
            w_ascii = 8'h23;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_prev_code    <= 12'h000;
            r_prev_invalid <= 1'b0;
            r_count        <= 4'd0;
        end else begin
            r_prev_code    <= w_code;
            r_prev_invalid <= w_invalid;
            r_count        <= w_count_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_FREE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_FREE: begin
                if (w_key_valid && w_stable) begin
                    w_state_next = ST_LATCHED;
                end
            end
            ST_LATCHED: begin
                if (w_is_zero && w_stable) begin
                    w_state_next = ST_FREE;
                end
            end
            default: w_state_next = ST_FREE;
        endcase
    end

    always_comb begin
        w_accept  = 1'b0;
        w_release = 1'b0;
        case (r_state)
            ST_FREE:    w_accept  = w_key_valid && w_stable;
            ST_LATCHED: w_release = w_is_zero && w_stable;
            default: begin
                w_accept  = 1'b0;
                w_release = 1'b0;
            end
        endcase
    end

    // LCD_DATA deliberately survives release; only a new press or reset changes it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_lcd_data <= 8'h00;
            r_chk      <= 1'b0;
            r_star     <= 1'b0;
            r_sharp    <= 1'b0;
        end else begin
            r_chk <= w_accept;
            if (w_accept) begin
                r_lcd_data <= w_ascii;
                r_star     <= w_code[10];
                r_sharp    <= w_code[11];
            end else if (w_release) begin
                r_star  <= 1'b0;
                r_sharp <= 1'b0;
            end
        end
    end

    assign LCD_DATA = r_lcd_data;
    assign CHK      = r_chk;
    assign star     = r_star;
    assign sharp    = r_sharp;
    assign o_state  = r_state;

endmodule

// File: tb/tb_keypad_encoder.sv
// Bench for keypad_encoder: directed test-plan sequences plus random key activity, checked by a
// history-window reference model feeding an expected-press queue and per-cycle level expectations.
module tb_keypad_encoder;

    localparam int DB = 2;

    logic        CLK;
    logic        RST;
    logic [11:0] Keypad;
    logic [7:0]  LCD_DATA;
    logic        CHK;
    logic        star;
    logic        sharp;
    logic [0:0]  dbg_state;

    int total;
    int bad;

    logic [9:0] exp_q[$];
    int         hist[$];
    logic       m_latch;
    logic [7:0] m_lcd;
    logic       m_chk;
    logic       m_star;
    logic       m_sharp;
    string      key_chars;

    keypad_encoder #(.DEBOUNCE(DB)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .Keypad   (Keypad),
        .LCD_DATA (LCD_DATA),
        .CHK      (CHK),
        .star     (star),
        .sharp    (sharp),
        .o_state  (dbg_state)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sample class: 0..11 key index, 12 idle, -1 invalid multi-key.
    function automatic int classify(input logic [11:0] k);
        int low;
        low = -1;
        for (int i = 11; i >= 0; i--) begin
            if (k[i]) low = i;
        end
        if (k == 12'h000) return 12;
`ifdef KEYPAD_PRIORITY_EN
        return low;
`else
        if ($countones(k) == 1) return low;
        return -1;
`endif
    endfunction

    // Apply one sample for the next rising edge and advance the model for that edge.
    task automatic step(input logic [11:0] key, input logic rst);
        bit all_same;
        int s;
        @(negedge CLK);
        Keypad = key;
        RST    = rst;
        m_chk  = 1'b0;
        if (rst) begin
            hist.delete();
            m_latch = 1'b0;
            m_lcd   = 8'h00;
            m_star  = 1'b0;
            m_sharp = 1'b0;
        end else begin
            s = classify(key);
            hist.push_back(s);
            if (hist.size() > DB) void'(hist.pop_front());
            all_same = (hist.size() == DB);
            foreach (hist[i]) if (hist[i] != hist[0]) all_same = 0;
            if (!m_latch && all_same && hist[0] >= 0 && hist[0] <= 11) begin
                m_latch = 1'b1;
                m_chk   = 1'b1;
                m_lcd   = key_chars[hist[0]];
                m_star  = (hist[0] == 10);
                m_sharp = (hist[0] == 11);
                exp_q.push_back({m_star, m_sharp, m_lcd});
            end else if (m_latch && all_same && hist[0] == 12) begin
                m_latch = 1'b0;
                m_star  = 1'b0;
                m_sharp = 1'b0;
            end
        end
    endtask

    task automatic hold(input logic [11:0] key, input int n);
        for (int i = 0; i < n; i++) step(key, 1'b0);
    endtask

    // Monitor: per-edge levels plus queue pop whenever the DUT strobes CHK.
    always @(posedge CLK) begin
        logic [9:0] e;
        #1;
        check("chk_level", {31'b0, CHK}, {31'b0, m_chk});
        check("lcd_data", {24'b0, LCD_DATA}, {24'b0, m_lcd});
        check("star", {31'b0, star}, {31'b0, m_star});
        check("sharp", {31'b0, sharp}, {31'b0, m_sharp});
        if (CHK === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL chk_unexpected: got CHK=1 with lcd=%0h expected no press at %0t",
                         LCD_DATA, $time);
            end else begin
                e = exp_q.pop_front();
                check("press_data", {22'b0, star, sharp, LCD_DATA}, {22'b0, e});
            end
        end
    end

    initial begin
        logic [11:0] k;
        int          kind;
        total     = 0;
        bad       = 0;
        key_chars = "0123456789*#";
        RST       = 1'b1;
        Keypad    = 12'h000;
        m_latch   = 1'b0;
        m_lcd     = 8'h00;
        m_chk     = 1'b0;
        m_star    = 1'b0;
        m_sharp   = 1'b0;

        step(12'h000, 1'b1);
        step(12'h000, 1'b0);
        hold(12'h002, 5);
        hold(12'h000, 3);
        hold(12'h008, 3);
        hold(12'h000, 3);
        hold(12'h080, 3);
        hold(12'h000, 3);
        hold(12'h400, 5);
        hold(12'h000, 3);
        hold(12'h800, 4);
        hold(12'h000, 3);
        hold(12'h010, 1);
        hold(12'h000, 3);
        hold(12'h006, 4);
        hold(12'h000, 3);
        hold(12'h002, 3);
        hold(12'h004, 4);
        hold(12'h000, 3);
        hold(12'h020, 3);
        step(12'h020, 1'b1);
        hold(12'h020, 3);
        hold(12'h000, 3);

        for (int n = 0; n < 400; n++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 3)      k = 12'h000;
            else if (kind <= 7) k = 12'h001 << $urandom_range(0, 11);
            else                k = 12'($urandom_range(0, 4095));
            if ($urandom_range(0, 39) == 0) step(k, 1'b1);
            else                            hold(k, $urandom_range(1, 4));
        end
        hold(12'h000, 4);
        @(negedge CLK);

        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_encoder.md
Name: keypad_encoder

Overview:
- Encodes a 12-key telephone keypad into ASCII characters for the LCD path.
- Samples the one-hot key lines on the system clock and debounces them.
- On each accepted press: updates LCD_DATA with the key's ASCII code, pulses CHK for one cycle, and flags the star/sharp keys on dedicated level outputs.
- Sits between the raw keypad pins and the LCD/entry control logic.

Parameters:
- DEBOUNCE, 2: number of consecutive rising CLK edges a key code must be stable before a press is accepted. The same count of all-zero edges is required before a release is accepted. Legal range 1..15.

Ports:
- CLK  input  1  system clock; all state changes on its rising edge.
- RST  input  1  synchronous, active-high reset.
- Keypad  input  12  one-hot key lines, active high. Bits 0..9 are digits 0..9, bit 10 is '*', bit 11 is '#'.
- LCD_DATA  output  8  ASCII code of the last accepted key.
- CHK  output  1  one-cycle strobe: new key accepted, LCD_DATA valid.
- star  output  1  high while an accepted '*' press is latched.
- sharp  output  1  high while an accepted '#' press is latched.

Behaviour:
- Reset: at any rising edge with RST=1, the following are cleared regardless of Keypad: LCD_DATA=8'h00, CHK=0, star=0, sharp=0, press latch cleared, debounce state cleared.
- Code classification each edge:
  - exactly one bit set = valid key;
  - all zero = idle;
  - two or more bits set = invalid.
- ASCII map:
  - bit i (0..9) -> 8'h30+i;
  - bit 10 -> 8'h2A ('*');
  - bit 11 -> 8'h23 ('#').
- Debounce: tracks the current code and a saturating stability count. The count restarts at 1 whenever the code differs from the previous edge's code.
- Press acceptance: requires all of the following:
  - latch clear;
  - valid code seen on DEBOUNCE consecutive edges, current edge included.
- At the accepting edge:
  - LCD_DATA <= ASCII(code);
  - CHK <= 1;
  - latch set;
  - star <= (code is bit 10); sharp <= (code is bit 11).
- Latency: with DEBOUNCE=2, a key first sampled at edge E0 and still present at E1 yields LCD_DATA/CHK updated at E1. With DEBOUNCE=1 the update occurs at E0.
- CHK is high for exactly one cycle per accepted press. It deasserts at the next edge even while the key is held; there is no auto-repeat.
- Release: requires latch set and an all-zero code on DEBOUNCE consecutive edges. At the release edge, the latch clears and star/sharp go 0. LCD_DATA keeps the last character.
- Key switched to a different valid key without an idle gap: no new press. The release must be seen first.
- Invalid code (multi-key): resets the stability count. It neither accepts a press nor counts toward release.
- Glitch shorter than DEBOUNCE edges: ignored, no CHK.
- Reset mid-press: the latch is lost. A key still held after RST falls is re-qualified from its first post-reset edge and produces a new press.

Optional Feature:
- KEYPAD_PRIORITY_EN defined: a multi-key code is resolved to its lowest-index set bit and treated as that valid key for debounce and acceptance.
- KEYPAD_PRIORITY_EN undefined: multi-key codes are invalid, as specified above.

Test Plan:
- Reset check: RST=1 for one edge -> LCD_DATA=8'h00, CHK=0, star=0, sharp=0.
- Digit press (DEBOUNCE=2): Keypad=12'h002 held 5 edges, then 12'h000 held 3 edges -> CHK high exactly one cycle at the 2nd sampled edge; LCD_DATA=8'h31 and held after release; no second CHK.
- Consecutive digits: press 12'h008, release, then press 12'h080 -> two CHK pulses; LCD_DATA 8'h33 then 8'h37.
- Star key: Keypad=12'h400 held 5 edges -> LCD_DATA=8'h2A, star=1 until 2 idle edges after release, sharp=0.
- Sharp key: Keypad=12'h800 held 4 edges -> LCD_DATA=8'h23, sharp=1 then 0 after release.
- Boundaries:
  - 1-edge glitch 12'h010 -> no CHK;
  - 12'h006 -> no CHK without the macro; with KEYPAD_PRIORITY_EN -> 8'h31;
  - 12'h002 switched directly to 12'h004 -> no second CHK.
